// File: rtl/kv_sort_engine_pkg.sv
// Shared types for the key+payload gnome sort engine: FSM states, sort order
// and the packed record width.
package kv_sort_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_READ,
    S_CMP,
    S_SWAP,
    S_OUT
  } sort_state_t;

  typedef enum logic {
    ASC  = 1'b0,
    DESC = 1'b1
  } order_t;

  // Record stored in RAM is {key, payload}
  function automatic int rec_width(input int kwidth, input int pwidth);
    return kwidth + pwidth;
  endfunction

endpackage

// File: rtl/kv_sort_engine_if.sv
// Avalon-ST input and output streams of the sort engine. Signal suffixes are
// seen from the engine: _i flows into it, _o flows out of it.
interface kv_sort_engine_if #(
  parameter int KWIDTH = 8,
  parameter int PWIDTH = 8
);

  logic              in_valid_i;
  logic              in_ready_o;
  logic [KWIDTH-1:0] in_key_i;
  logic [PWIDTH-1:0] in_payload_i;
  logic              in_sop_i;
  logic              in_eop_i;
  logic              in_desc_i;
  logic              out_ready_i;
  logic              out_valid_o;
  logic [KWIDTH-1:0] out_key_o;
  logic [PWIDTH-1:0] out_payload_o;
  logic              out_sop_o;
  logic              out_eop_o;

  modport slave (
    input  in_valid_i, in_key_i, in_payload_i, in_sop_i, in_eop_i, in_desc_i,
    input  out_ready_i,
    output in_ready_o,
    output out_valid_o, out_key_o, out_payload_o, out_sop_o, out_eop_o
  );

  modport master (
    output in_valid_i, in_key_i, in_payload_i, in_sop_i, in_eop_i, in_desc_i,
    output out_ready_i,
    input  in_ready_o,
    input  out_valid_o, out_key_o, out_payload_o, out_sop_o, out_eop_o
  );

endinterface

// File: rtl/kv_sort_engine_ram.sv
// True dual-port single-clock RAM. Address is registered, so read data lags
// the address by one cycle; REGISTER_OUT adds an optional output stage.
module true_dual_port_ram_single_clock #(
  parameter int DATA_WIDTH   = 16,
  parameter int ADDR_WIDTH   = 5,
  parameter int REGISTER_OUT = 0
) (
  input  logic                  clk_i,
  input  logic                  we_a_i,
  input  logic                  we_b_i,
  input  logic [ADDR_WIDTH-1:0] addr_a_i,
  input  logic [ADDR_WIDTH-1:0] addr_b_i,
  input  logic [DATA_WIDTH-1:0] data_a_i,
  input  logic [DATA_WIDTH-1:0] data_b_i,
  output logic [DATA_WIDTH-1:0] q_a_o,
  output logic [DATA_WIDTH-1:0] q_b_o
);

  logic [DATA_WIDTH-1:0] mem_q [2**ADDR_WIDTH];
  logic [ADDR_WIDTH-1:0] addr_a_q;
  logic [ADDR_WIDTH-1:0] addr_b_q;
  logic [DATA_WIDTH-1:0] rd_a;
  logic [DATA_WIDTH-1:0] rd_b;

  always_ff @(posedge clk_i) begin
    if (we_a_i) mem_q[addr_a_i] <= data_a_i;
    if (we_b_i) mem_q[addr_b_i] <= data_b_i;
    addr_a_q <= addr_a_i;
    addr_b_q <= addr_b_i;
  end

  assign rd_a = mem_q[addr_a_q];
  assign rd_b = mem_q[addr_b_q];

  generate
    if (REGISTER_OUT != 0) begin : g_out_reg
      always_ff @(posedge clk_i) begin
        q_a_o <= rd_a;
        q_b_o <= rd_b;
      end
    end else begin : g_out_comb
      assign q_a_o = rd_a;
      assign q_b_o = rd_b;
    end
  endgenerate

endmodule

// File: rtl/kv_sort_engine.sv
// In-place stable gnome sort of one {key, payload} packet held in a dual-port
// RAM, with Avalon-ST load/unload, per-packet order, overflow and abort.
module kv_sort_engine
  import kv_sort_pkg::*;
#(
  parameter int AWIDTH = 5,
  parameter int KWIDTH = 8,
  parameter int PWIDTH = 8
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              abort_i,
  kv_sort_engine_if.slave   bus,
  output logic              busy_o,
  output logic              overflow_o,
  output logic [AWIDTH:0]   count_o
);

  localparam int RW = rec_width(KWIDTH, PWIDTH);
  localparam logic [AWIDTH:0] ONE     = (AWIDTH+1)'(1);
  localparam logic [AWIDTH:0] TWO     = (AWIDTH+1)'(2);
  localparam logic [AWIDTH:0] DEPTH_C = ONE << AWIDTH;

  sort_state_t     state_q, state_d;
  logic [AWIDTH:0] count_q, count_d;
  logic [AWIDTH:0] i_q, i_d;
  logic [AWIDTH:0] j_q, j_d;
  logic [AWIDTH:0] shown_q, shown_d;
  order_t          order_q, order_d;
  logic            overflow_q, overflow_d;
  logic            busy_q, busy_d;
  logic            out_valid_q, out_valid_d;

  logic              we_a, we_b;
  logic [AWIDTH-1:0] addr_a, addr_b;
  logic [RW-1:0]     wdata_a, wdata_b;
  logic [RW-1:0]     q_a, q_b;

  logic              in_ready;
  logic              accept;
  logic              fire;
  logic              do_swap;
  logic [AWIDTH:0]   i_m1;
  logic [AWIDTH:0]   last_idx;
  logic [KWIDTH-1:0] key_a, key_b;
  logic [RW-1:0]     in_rec;

  // A beat offered together with abort_i must not complete a handshake
  assign in_ready = ((state_q == S_IDLE) || (state_q == S_LOAD)) && !abort_i;
  assign accept   = bus.in_valid_i && in_ready;
  assign fire     = out_valid_q && bus.out_ready_i;
  assign in_rec   = {bus.in_key_i, bus.in_payload_i};
  assign i_m1     = i_q - ONE;
  assign last_idx = count_q - ONE;
  assign key_a    = q_a[RW-1 -: KWIDTH];
  assign key_b    = q_b[RW-1 -: KWIDTH];
  // Strict compare keeps equal keys in arrival order
  assign do_swap  = (order_q == DESC) ? (key_b < key_a) : (key_b > key_a);

  always_comb begin
    state_d     = state_q;
    count_d     = count_q;
    i_d         = i_q;
    j_d         = j_q;
    shown_d     = shown_q;
    order_d     = order_q;
    overflow_d  = overflow_q;
    busy_d      = busy_q;
    out_valid_d = 1'b0;
    we_a        = 1'b0;
    we_b        = 1'b0;
    addr_a      = i_q[AWIDTH-1:0];
    addr_b      = i_m1[AWIDTH-1:0];
    wdata_a     = in_rec;
    wdata_b     = q_a;

    case (state_q)
      S_IDLE, S_LOAD: begin
        if (accept) begin
          if (bus.in_sop_i) begin
            we_a       = 1'b1;
            addr_a     = '0;
            count_d    = ONE;
            order_d    = order_t'(bus.in_desc_i);
            overflow_d = 1'b0;
            busy_d     = 1'b1;
            shown_d    = '0;
            state_d    = bus.in_eop_i ? S_OUT : S_LOAD;
          end else if (state_q == S_LOAD) begin
            if (count_q == DEPTH_C) begin
              overflow_d = 1'b1;
            end else begin
              we_a    = 1'b1;
              addr_a  = count_q[AWIDTH-1:0];
              count_d = count_q + ONE;
            end
            if (bus.in_eop_i) begin
              shown_d = '0;
              if (count_d == ONE) begin
                state_d = S_OUT;
              end else begin
                state_d = S_READ;
                i_d     = ONE;
                j_d     = TWO;
              end
            end
          end
        end
      end
      S_READ: begin
        if (i_q >= count_q) begin
          state_d = S_OUT;
          shown_d = '0;
        end else begin
          state_d = S_CMP;
        end
      end
      S_CMP: begin
        if (do_swap) begin
          state_d = S_SWAP;
        end else begin
          i_d     = j_q;
          j_d     = j_q + ONE;
          state_d = S_READ;
        end
      end
      S_SWAP: begin
        // Addresses are still i / i-1 from READ, so q_a/q_b hold both records
        we_a    = 1'b1;
        we_b    = 1'b1;
        wdata_a = q_b;
        wdata_b = q_a;
        i_d     = i_m1;
        if (i_m1 == '0) begin
          i_d = j_q;
          j_d = j_q + ONE;
        end
        state_d = S_READ;
      end
      S_OUT: begin
        if (fire && (shown_q == last_idx)) begin
          state_d = S_IDLE;
          busy_d  = 1'b0;
        end else begin
          // Re-reading the same address while stalled keeps the beat stable
          if (fire) shown_d = shown_q + ONE;
          out_valid_d = 1'b1;
          addr_a      = shown_d[AWIDTH-1:0];
        end
      end
      default: state_d = S_IDLE;
    endcase

    if (abort_i) begin
      state_d     = S_IDLE;
      count_d     = '0;
      busy_d      = 1'b0;
      overflow_d  = 1'b0;
      out_valid_d = 1'b0;
      we_a        = 1'b0;
      we_b        = 1'b0;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q     <= S_IDLE;
      count_q     <= '0;
      i_q         <= '0;
      j_q         <= '0;
      shown_q     <= '0;
      order_q     <= ASC;
      overflow_q  <= 1'b0;
      busy_q      <= 1'b0;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      count_q     <= count_d;
      i_q         <= i_d;
      j_q         <= j_d;
      shown_q     <= shown_d;
      order_q     <= order_d;
      overflow_q  <= overflow_d;
      busy_q      <= busy_d;
      out_valid_q <= out_valid_d;
    end
  end

  true_dual_port_ram_single_clock #(
    .DATA_WIDTH  (RW),
    .ADDR_WIDTH  (AWIDTH),
    .REGISTER_OUT(0)
  ) u_ram (
    .clk_i   (clk_i),
    .we_a_i  (we_a),
    .we_b_i  (we_b),
    .addr_a_i(addr_a),
    .addr_b_i(addr_b),
    .data_a_i(wdata_a),
    .data_b_i(wdata_b),
    .q_a_o   (q_a),
    .q_b_o   (q_b)
  );

  assign bus.in_ready_o    = in_ready;
  assign bus.out_valid_o   = out_valid_q;
  assign bus.out_key_o     = key_a;
  assign bus.out_payload_o = q_a[PWIDTH-1:0];
  assign bus.out_sop_o     = out_valid_q && (shown_q == '0);
  assign bus.out_eop_o     = out_valid_q && (shown_q == last_idx);
  assign busy_o            = busy_q;
  assign overflow_o        = overflow_q;
  assign count_o           = count_q;

endmodule

// File: tb/tb_kv_sort_engine.sv
// Directed bench: a 32-deep and an 8-deep engine share all stimulus; one of
// them is selected for checking in each test.
module tb_kv_sort_engine;
  import kv_sort_pkg::*;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst, abort, in_valid, in_sop, in_eop, in_desc, out_ready;
  logic [7:0] in_key, in_pl;
  logic       sel;

  kv_sort_engine_if #(.KWIDTH(8), .PWIDTH(8)) if5 ();
  kv_sort_engine_if #(.KWIDTH(8), .PWIDTH(8)) if3 ();

  assign if5.in_valid_i = in_valid;   assign if3.in_valid_i = in_valid;
  assign if5.in_key_i = in_key;       assign if3.in_key_i = in_key;
  assign if5.in_payload_i = in_pl;    assign if3.in_payload_i = in_pl;
  assign if5.in_sop_i = in_sop;       assign if3.in_sop_i = in_sop;
  assign if5.in_eop_i = in_eop;       assign if3.in_eop_i = in_eop;
  assign if5.in_desc_i = in_desc;     assign if3.in_desc_i = in_desc;
  assign if5.out_ready_i = out_ready; assign if3.out_ready_i = out_ready;

  logic       busy5, ovf5, busy3, ovf3;
  logic [5:0] count5;
  logic [3:0] count3;

  kv_sort_engine #(.AWIDTH(5), .KWIDTH(8), .PWIDTH(8)) u_dut5 (
    .clk_i(clk), .rst_i(rst), .abort_i(abort), .bus(if5),
    .busy_o(busy5), .overflow_o(ovf5), .count_o(count5)
  );

  kv_sort_engine #(.AWIDTH(3), .KWIDTH(8), .PWIDTH(8)) u_dut3 (
    .clk_i(clk), .rst_i(rst), .abort_i(abort), .bus(if3),
    .busy_o(busy3), .overflow_o(ovf3), .count_o(count3)
  );

  logic       s_valid, s_ready, s_sop, s_eop, s_busy, s_ovf;
  logic [7:0] s_key, s_pl;
  logic [5:0] s_count;
  assign s_valid = sel ? if3.out_valid_o   : if5.out_valid_o;
  assign s_ready = sel ? if3.in_ready_o    : if5.in_ready_o;
  assign s_sop   = sel ? if3.out_sop_o     : if5.out_sop_o;
  assign s_eop   = sel ? if3.out_eop_o     : if5.out_eop_o;
  assign s_key   = sel ? if3.out_key_o     : if5.out_key_o;
  assign s_pl    = sel ? if3.out_payload_o : if5.out_payload_o;
  assign s_busy  = sel ? busy3 : busy5;
  assign s_ovf   = sel ? ovf3  : ovf5;
  assign s_count = sel ? {2'b00, count3} : count5;

  typedef struct {
    logic [7:0] in_key;
    logic [7:0] in_pl;
    logic [7:0] exp_key;
    logic [7:0] exp_pl;
  } vec_t;

  vec_t vecs [0:23];
  int   n_cmp  = 0;
  int   n_fail = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic set_vec(input int idx, input logic [7:0] ik, ip, ek, ep);
    vecs[idx].in_key  = ik;
    vecs[idx].in_pl   = ip;
    vecs[idx].exp_key = ek;
    vecs[idx].exp_pl  = ep;
  endtask

  task automatic send_beat(input logic [7:0] k, p, input logic sop, eop, desc);
    int guard;
    @(negedge clk);
    in_valid = 1'b1; in_key = k; in_pl = p; in_sop = sop; in_eop = eop; in_desc = desc;
    #1;
    guard = 0;
    while (!(if5.in_ready_o && if3.in_ready_o) && guard < 50) begin
      @(negedge clk); #1; guard++;
    end
    if (guard >= 50) check("in_ready_timeout", 32'(if5.in_ready_o && if3.in_ready_o), 32'd1);
  endtask

  task automatic end_beats();
    @(negedge clk);
    in_valid = 1'b0; in_sop = 1'b0; in_eop = 1'b0;
  endtask

  task automatic send_pkt(input int base, input int n, input logic desc);
    for (int k = 0; k < n; k++)
      send_beat(vecs[base+k].in_key, vecs[base+k].in_pl, k == 0, k == n - 1, desc);
    end_beats();
  endtask

  task automatic wait_idle();
    int guard;
    guard = 0;
    while ((busy5 || busy3) && guard < 3000) begin
      @(negedge clk); guard++;
    end
    if (guard >= 3000) check("idle_timeout", 32'(busy5 || busy3), 32'd0);
  endtask

  // Takes n_take handshakes of an n_total packet; stall=1 uses ready 1,0,0,...
  task automatic receive(input string tag, input int base, input int n_total,
                         input int n_take, input logic stall);
    int         k, cyc;
    logic       held, hs, he;
    logic [7:0] hk, hp;
    k = 0; cyc = 0; held = 1'b0;
    hk = '0; hp = '0; hs = 1'b0; he = 1'b0;
    while (k < n_take && cyc < 5000) begin
      @(negedge clk);
      out_ready = stall ? (cyc % 3 == 0) : 1'b1;
      #1;
      if (s_valid) begin
        if (held) begin
          check({tag, "_hold_key"}, 32'(s_key), 32'(hk));
          check({tag, "_hold_pl"},  32'(s_pl),  32'(hp));
          check({tag, "_hold_sop"}, 32'(s_sop), 32'(hs));
          check({tag, "_hold_eop"}, 32'(s_eop), 32'(he));
        end
        if (out_ready) begin
          check($sformatf("%s_key%0d", tag, k), 32'(s_key), 32'(vecs[base+k].exp_key));
          check($sformatf("%s_pl%0d", tag, k),  32'(s_pl),  32'(vecs[base+k].exp_pl));
          check($sformatf("%s_sop%0d", tag, k), 32'(s_sop), 32'(k == 0));
          check($sformatf("%s_eop%0d", tag, k), 32'(s_eop), 32'(k == n_total - 1));
          k++;
          held = 1'b0;
        end else begin
          held = 1'b1; hk = s_key; hp = s_pl; hs = s_sop; he = s_eop;
        end
      end
      cyc++;
    end
    if (k < n_take) check({tag, "_recv_timeout"}, 32'(k), 32'(n_take));
    $display("%s: received %0d records", tag, k);
  endtask

  initial begin
    rst = 1'b1; abort = 1'b0; in_valid = 1'b0; in_sop = 1'b0; in_eop = 1'b0;
    in_desc = 1'b0; in_key = '0; in_pl = '0; out_ready = 1'b0; sel = 1'b0;

    // ascending / descending: (3,A)(1,B)(4,C)(1,D)(5,E)
    set_vec(0, 8'd3, "A", 8'd1, "B"); set_vec(5, 8'd3, "A", 8'd5, "E");
    set_vec(1, 8'd1, "B", 8'd1, "D"); set_vec(6, 8'd1, "B", 8'd4, "C");
    set_vec(2, 8'd4, "C", 8'd3, "A"); set_vec(7, 8'd4, "C", 8'd3, "A");
    set_vec(3, 8'd1, "D", 8'd4, "C"); set_vec(8, 8'd1, "D", 8'd1, "B");
    set_vec(4, 8'd5, "E", 8'd5, "E"); set_vec(9, 8'd5, "E", 8'd1, "D");
    set_vec(10, 8'd7, 8'h77, 8'd7, 8'h77);
    // overflow: keys 9..0 in, first 8 stored (9..2) come out as 2..9
    for (int k = 0; k < 10; k++)
      set_vec(11 + k, 8'(9 - k), 8'(8'hA0 + 9 - k), 8'(2 + k), 8'(8'hA2 + k));
    set_vec(21, 8'd2, 8'h21, 8'd0, 8'h22);
    set_vec(22, 8'd0, 8'h22, 8'd1, 8'h23);
    set_vec(23, 8'd1, 8'h23, 8'd2, 8'h21);

    @(negedge clk); @(negedge clk); #1;
    check("rst_in_ready", 32'(s_ready), 32'd1);
    check("rst_out_valid", 32'(s_valid), 32'd0);
    check("rst_sop", 32'(s_sop), 32'd0);
    check("rst_eop", 32'(s_eop), 32'd0);
    check("rst_busy", 32'(s_busy), 32'd0);
    check("rst_overflow", 32'(s_ovf), 32'd0);
    check("rst_count", 32'(s_count), 32'd0);
    rst = 1'b0;

    // stable ascending
    sel = 1'b0; wait_idle();
    send_pkt(0, 5, 1'b0); #1;
    check("asc_count", 32'(s_count), 32'd5);
    check("asc_busy", 32'(s_busy), 32'd1);
    receive("asc", 0, 5, 5, 1'b0);

    // descending with back-pressure
    wait_idle();
    send_pkt(5, 5, 1'b1);
    receive("desc", 5, 5, 5, 1'b1);

    // single record
    wait_idle();
    send_pkt(10, 1, 1'b0);
    receive("single", 10, 1, 1, 1'b0);
    @(negedge clk); #1;
    check("single_busy_after", 32'(s_busy), 32'd0);
    check("single_ready_after", 32'(s_ready), 32'd1);
    check("single_valid_after", 32'(s_valid), 32'd0);

    // overflow on the 8-deep engine, then cleared by the next sop
    sel = 1'b1; wait_idle();
    send_pkt(11, 10, 1'b0); #1;
    check("ovf_flag", 32'(s_ovf), 32'd1);
    check("ovf_count", 32'(s_count), 32'd8);
    receive("ovf", 11, 8, 8, 1'b0);
    wait_idle();
    send_pkt(21, 3, 1'b0); #1;
    check("ovf_cleared", 32'(s_ovf), 32'd0);
    check("ovf_next_count", 32'(s_count), 32'd3);
    receive("after_ovf", 21, 3, 3, 1'b0);

    // abort while swapping a reversed 32-record packet
    sel = 1'b0; wait_idle();
    for (int k = 0; k < 32; k++)
      send_beat(8'(31 - k), 8'(k), k == 0, k == 31, 1'b0);
    end_beats();
    begin
      int guard;
      guard = 0;
      while (u_dut5.state_q != S_SWAP && guard < 200) begin
        @(negedge clk); guard++;
      end
      check("abort_reached_swap", 32'(u_dut5.state_q == S_SWAP), 32'd1);
    end
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0; #1;
    check("abort_valid", 32'(s_valid), 32'd0);
    check("abort_sop", 32'(s_sop), 32'd0);
    check("abort_eop", 32'(s_eop), 32'd0);
    check("abort_busy", 32'(s_busy), 32'd0);
    check("abort_count", 32'(s_count), 32'd0);
    check("abort_overflow", 32'(s_ovf), 32'd0);
    check("abort_ready", 32'(s_ready), 32'd1);
    check("abort_small_ovf", 32'(ovf3), 32'd0);
    wait_idle();
    send_pkt(21, 3, 1'b0);
    receive("after_abort", 21, 3, 3, 1'b0);

    // asynchronous reset while output is valid
    wait_idle();
    send_pkt(0, 5, 1'b0);
    receive("pre_rst", 0, 5, 2, 1'b0);
    @(negedge clk);
    out_ready = 1'b0; #1;
    check("pre_rst_valid", 32'(s_valid), 32'd1);
    rst = 1'b1; #1;
    check("mid_rst_valid", 32'(s_valid), 32'd0);
    check("mid_rst_sop", 32'(s_sop), 32'd0);
    check("mid_rst_eop", 32'(s_eop), 32'd0);
    check("mid_rst_busy", 32'(s_busy), 32'd0);
    check("mid_rst_count", 32'(s_count), 32'd0);
    check("mid_rst_overflow", 32'(s_ovf), 32'd0);
    check("mid_rst_ready", 32'(s_ready), 32'd1);
    @(negedge clk);
    rst = 1'b0; #1;
    check("post_rst_ready", 32'(s_ready), 32'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
